rc4_prga_stream: RTL and testbench
==================================

Name: rc4_prga_stream

Overview:
- Parametrised RC4 keystream-generation and decrypt engine (PRGA phase).
- Runs after the KSA has filled the 256-byte S working RAM. It swaps S entries, generates keystream bytes, and XORs them with the encrypted-message ROM into the decrypted-message RAM.
- Generalises the fixed 32-byte decrypt FSM in three ways: configurable message length, configurable RAM/ROM read latency, and an optional plaintext-validity check mode that aborts early, for use by the key-search controller.

Parameters:
- MSG_LEN, 32: number of message bytes to decrypt (2..256).
- READ_LAT, 1: read latency in cycles of the S RAM and the message ROM (1..4).
- K_W, $clog2(MSG_LEN): message address width (derived; do not override).

Ports:
- clk, input, 1: clock.
- rst_n, input, 1: asynchronous active-low reset.
- start, input, 1: level; sampled only in IDLE.
- check_en, input, 1: enables validity check; latched when start is accepted.
- s_addr, output, 8: S RAM address.
- s_wdata, output, 8: S RAM write data.
- s_we, output, 1: S RAM write enable.
- s_rdata, input, 8: S RAM read data.
- msg_addr, output, K_W: encrypted ROM address.
- msg_rdata, input, 8: encrypted ROM data.
- out_addr, output, K_W: decrypted RAM address.
- out_wdata, output, 8: decrypted RAM write data.
- out_we, output, 1: decrypted RAM write enable.
- busy, output, 1: high from start acceptance until the DONE state.
- done, output, 1: one-cycle pulse at completion or abort.
- pass, output, 1: result of the last run; held until the next start.
- fail_k, output, K_W: index of the first invalid byte; held until the next start.

Behaviour:
- Reset (async, rst_n=0): FSM goes to IDLE. All outputs are 0. Internal i, j, k, si, sj, f and the wait counter are 0.
- Reset mid-operation returns to IDLE immediately. No further writes occur; partial output is left in the RAMs.
- Start handshake:
  - In IDLE with start=1: latch check_en, go to INIT.
  - start is ignored in all other states, so re-triggering is impossible while busy.
- INIT (1 cycle): i=0, j=0, k=0, pass=0, fail_k=0.
- Read phase definition: the address is held for READ_LAT+1 cycles. Data is sampled on the last of those cycles. A wait counter counts READ_LAT cycles.
- Per-byte sequence:
  - RD_I: s_addr=i+1 (mod 256); i updated to i+1 on entry. On sample: si=s_rdata, and j=j+s_rdata (mod 256).
  - RD_J: s_addr=j. On sample: sj=s_rdata.
  - WR_J (1 cycle): s_addr=j, s_wdata=si, s_we=1.
  - WR_I (1 cycle): s_addr=i, s_wdata=sj, s_we=1.
  - RD_F: s_addr=si+sj (mod 256), and msg_addr=k concurrently. On sample: f=s_rdata, enc=msg_rdata.
  - XOR_WR (1 cycle): d=f^enc.
    - If check is off, or d is valid: out_addr=k, out_wdata=d, out_we=1.
    - If k==MSG_LEN-1, go to DONE with pass=1. Otherwise k=k+1 and go to RD_I.
    - If check is on and d is invalid: out_we=0, fail_k=k, pass=0, go to DONE.
- Valid byte definition: 0x61..0x7A ('a'..'z') or 0x20.
- Cycles per byte: 3*(READ_LAT+1)+3 = 3*READ_LAT+6.
- DONE (1 cycle): done=1, busy=0, then go to IDLE.
- busy=1 in INIT through XOR_WR inclusive.
- Completion timing: with the start-sampling edge as cycle 0, done is high in cycle 2+MSG_LEN*(3*READ_LAT+6).
- i==j: both swap writes target the same address with equal data. No special handling.
- All arithmetic is 8-bit modulo 256. k never wraps because MSG_LEN<=256.
- s_we and out_we are never high together with a stale address. Addresses and data are combinational from the state plus registers and stable for the whole write cycle.

Decomposition:
- Package rc4_pkg: state enum typedef, BYTE_W=8, S_DEPTH=256, and the valid-character constants (CH_LO=0x61, CH_HI=0x7A, CH_SP=0x20).
- Sub-module rc4_char_check: combinational byte -> valid flag. Shared with the key-search controller.
- Wait counter and FSM stay in this module.

Test Plan:
- Identity S (S[x]=x), MSG_LEN=4, READ_LAT=1, check off, msg bytes 0x63, 0x64, ...:
  - out[0]=0x61 (keystream 0x02) and out[1]=0x61 (keystream 0x05).
  - S[2]=3 and S[3]=2 after byte 1.
  - done in cycle 38; pass=1.
- Same stimulus with READ_LAT=3: identical outputs; done in cycle 62.
- Check on, identity S, msg[1]=0x00 (decrypts to 0x05):
  - out[0] written; no write at k=1.
  - done pulse; pass=0, fail_k=1, busy=0.
- Random S permutation and message vs software RC4 model, MSG_LEN=32, check off: all 32 output bytes and the final S contents match.
- Assert rst_n=0 during WR_J of byte 2:
  - All outputs are 0 immediately; no further s_we or out_we.
  - A subsequent start runs correctly from i=j=k=0.
- start held high through a run and pulsed while busy:
  - Exactly one run per IDLE acceptance.
  - done is high for exactly 1 cycle; a new run begins the cycle after returning to IDLE.

Source files
------------

// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 PRGA engine and its helpers.
package rc4_pkg;

    localparam int BYTE_W  = 8;
    localparam int S_DEPTH = 256;

    // Printable range accepted as plausible plaintext: 'a'..'z' and space.
    localparam logic [BYTE_W-1:0] CH_LO = 8'h61;
    localparam logic [BYTE_W-1:0] CH_HI = 8'h7A;
    localparam logic [BYTE_W-1:0] CH_SP = 8'h20;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_INIT,
        ST_RD_I,
        ST_RD_J,
        ST_WR_J,
        ST_WR_I,
        ST_RD_F,
        ST_XOR_WR,
        ST_DONE
    } state_t;

endpackage

// File: rtl/rc4_char_check.sv
// Combinational plaintext-validity test: lower-case letter or space.
module rc4_char_check
    import rc4_pkg::*;
(
    input  logic [BYTE_W-1:0] ch,
    output logic              valid
);

    // Flag a byte as valid when it lies in 'a'..'z' or is a space.
    always_comb begin
        valid = ((ch >= CH_LO) && (ch <= CH_HI)) || (ch == CH_SP);
    end

endmodule

// File: rtl/rc4_prga_stream.sv
// RC4 PRGA engine: swaps S entries, forms keystream bytes and XORs them with
// the encrypted ROM into the decrypted RAM, optionally aborting on the first
// byte that does not look like plaintext.
//
// Memory interface: every read holds its address for READ_LAT+1 cycles and
// samples the returned data on the last of them; writes are single-cycle
// strobes whose address and data are combinational from state and registers.
module rc4_prga_stream
    import rc4_pkg::*;
#(
    parameter int MSG_LEN  = 32,
    parameter int READ_LAT = 1,
    parameter int K_W      = $clog2(MSG_LEN)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           check_en,
    output logic [7:0]     s_addr,
    output logic [7:0]     s_wdata,
    output logic           s_we,
    input  logic [7:0]     s_rdata,
    output logic [K_W-1:0] msg_addr,
    input  logic [7:0]     msg_rdata,
    output logic [K_W-1:0] out_addr,
    output logic [7:0]     out_wdata,
    output logic           out_we,
    output logic           busy,
    output logic           done,
    output logic           pass,
    output logic [K_W-1:0] fail_k
);

    localparam logic [2:0]     WAIT_LAST = 3'(READ_LAT);
    localparam logic [K_W-1:0] K_LAST    = K_W'(MSG_LEN - 1);

    state_t         state;
    state_t         next_state;
    logic [7:0]     i;
    logic [7:0]     j;
    logic [7:0]     si;
    logic [7:0]     sj;
    logic [7:0]     f;
    logic [7:0]     enc;
    logic [K_W-1:0] k;
    logic [2:0]     wait_cnt;
    logic           chk;
    logic [7:0]     d;
    logic           d_ok;
    logic           rd_state;
    logic           rd_last;
    logic           abort;

    assign d        = f ^ enc;
    assign rd_state = (state == ST_RD_I) || (state == ST_RD_J) || (state == ST_RD_F);
    assign rd_last  = rd_state && (wait_cnt == WAIT_LAST);
    assign abort    = chk && !d_ok;

    rc4_char_check u_char_check (
        .ch    (d),
        .valid (d_ok)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode: read states advance only once the data is sampled.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   if (start) next_state = ST_INIT;
            ST_INIT:   next_state = ST_RD_I;
            ST_RD_I:   if (rd_last) next_state = ST_RD_J;
            ST_RD_J:   if (rd_last) next_state = ST_WR_J;
            ST_WR_J:   next_state = ST_WR_I;
            ST_WR_I:   next_state = ST_RD_F;
            ST_RD_F:   if (rd_last) next_state = ST_XOR_WR;
            ST_XOR_WR: begin
                if (abort || (k == K_LAST)) next_state = ST_DONE;
                else                        next_state = ST_RD_I;
            end
            ST_DONE:   next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    // Datapath registers: indices, sampled S values, wait counter and result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i        <= 8'd0;
            j        <= 8'd0;
            k        <= '0;
            si       <= 8'd0;
            sj       <= 8'd0;
            f        <= 8'd0;
            enc      <= 8'd0;
            wait_cnt <= 3'd0;
            chk      <= 1'b0;
            pass     <= 1'b0;
            fail_k   <= '0;
        end else begin
            wait_cnt <= (rd_state && !rd_last) ? wait_cnt + 3'd1 : 3'd0;
            case (state)
                ST_IDLE: if (start) chk <= check_en;
                ST_INIT: begin
                    // i restarts at 0 and is bumped on entry to RD_I, so
                    // the first byte reads S[1].
                    i      <= 8'd1;
                    j      <= 8'd0;
                    k      <= '0;
                    pass   <= 1'b0;
                    fail_k <= '0;
                end
                ST_RD_I: begin
                    if (rd_last) begin
                        si <= s_rdata;
                        j  <= j + s_rdata;
                    end
                end
                ST_RD_J: if (rd_last) sj <= s_rdata;
                ST_RD_F: begin
                    if (rd_last) begin
                        f   <= s_rdata;
                        enc <= msg_rdata;
                    end
                end
                ST_XOR_WR: begin
                    if (abort) begin
                        fail_k <= k;
                        pass   <= 1'b0;
                    end else if (k == K_LAST) begin
                        pass <= 1'b1;
                    end else begin
                        k <= k + K_W'(1);
                        i <= i + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Output decode: addresses, write strobes and status from the state.
    always_comb begin
        s_addr    = 8'd0;
        s_wdata   = 8'd0;
        s_we      = 1'b0;
        msg_addr  = '0;
        out_addr  = '0;
        out_wdata = 8'd0;
        out_we    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            ST_INIT: busy = 1'b1;
            ST_RD_I: begin
                busy   = 1'b1;
                s_addr = i;
            end
            ST_RD_J: begin
                busy   = 1'b1;
                s_addr = j;
            end
            ST_WR_J: begin
                busy    = 1'b1;
                s_addr  = j;
                s_wdata = si;
                s_we    = 1'b1;
            end
            ST_WR_I: begin
                busy    = 1'b1;
                s_addr  = i;
                s_wdata = sj;
                s_we    = 1'b1;
            end
            ST_RD_F: begin
                busy     = 1'b1;
                s_addr   = si + sj;
                msg_addr = k;
            end
            ST_XOR_WR: begin
                busy = 1'b1;
                if (!abort) begin
                    out_addr  = k;
                    out_wdata = d;
                    out_we    = 1'b1;
                end
            end
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_rc4_prga_stream.sv
// Self-checking bench for rc4_prga_stream: three instances with different
// message lengths and read latencies, behavioural memories, and a software
// RC4 reference model.
module tb_rc4_prga_stream;

    localparam int N0 = 4;
    localparam int L0 = 1;
    localparam int N1 = 4;
    localparam int L1 = 3;
    localparam int N2 = 32;
    localparam int L2 = 2;

    function automatic int n_of(input int g);
        return (g == 0) ? N0 : (g == 1) ? N1 : N2;
    endfunction

    function automatic int l_of(input int g);
        return (g == 0) ? L0 : (g == 1) ? L1 : L2;
    endfunction

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT-facing signals ----------------
    logic       start       [3];
    logic       check_en    [3];
    logic [7:0] s_addr_w    [3];
    logic [7:0] s_wdata_w   [3];
    logic       s_we_w      [3];
    logic [7:0] s_rdata_w   [3];
    logic [7:0] msg_addr_w  [3];
    logic [7:0] msg_rdata_w [3];
    logic [7:0] out_addr_w  [3];
    logic [7:0] out_wdata_w [3];
    logic       out_we_w    [3];
    logic       busy_w      [3];
    logic       done_w      [3];
    logic       pass_w      [3];
    logic [7:0] fail_w      [3];

    // ---------------- behavioural memories ----------------
    logic [7:0] s_mem    [3][256];
    logic [7:0] msg_mem  [3][256];
    logic [7:0] out_mem  [3][256];
    logic [7:0] s_pipe   [3][4];
    logic [7:0] m_pipe   [3][4];
    int         swe_cnt  [3];
    int         owe_cnt  [3];
    logic [15:0] obs_q[$];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int N  = (g == 0) ? N0 : (g == 1) ? N1 : N2;
        localparam int L  = (g == 0) ? L0 : (g == 1) ? L1 : L2;
        localparam int KW = $clog2(N);
        logic [KW-1:0] ma;
        logic [KW-1:0] oa;
        logic [KW-1:0] fk;

        rc4_prga_stream #(.MSG_LEN(N), .READ_LAT(L)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .start     (start[g]),
            .check_en  (check_en[g]),
            .s_addr    (s_addr_w[g]),
            .s_wdata   (s_wdata_w[g]),
            .s_we      (s_we_w[g]),
            .s_rdata   (s_rdata_w[g]),
            .msg_addr  (ma),
            .msg_rdata (msg_rdata_w[g]),
            .out_addr  (oa),
            .out_wdata (out_wdata_w[g]),
            .out_we    (out_we_w[g]),
            .busy      (busy_w[g]),
            .done      (done_w[g]),
            .pass      (pass_w[g]),
            .fail_k    (fk)
        );

        assign msg_addr_w[g]  = 8'(ma);
        assign out_addr_w[g]  = 8'(oa);
        assign fail_w[g]      = 8'(fk);
        assign s_rdata_w[g]   = s_pipe[g][L-1];
        assign msg_rdata_w[g] = m_pipe[g][L-1];
    end

    // Memories: registered reads delayed through a READ_LAT-deep pipe,
    // single-cycle writes, and a log of every decrypted-RAM write.
    always @(posedge clk) begin
        for (int g = 0; g < 3; g++) begin
            for (int p = 3; p > 0; p--) begin
                s_pipe[g][p] <= s_pipe[g][p-1];
                m_pipe[g][p] <= m_pipe[g][p-1];
            end
            s_pipe[g][0] <= s_mem[g][s_addr_w[g]];
            m_pipe[g][0] <= msg_mem[g][msg_addr_w[g]];
            if (s_we_w[g]) begin
                s_mem[g][s_addr_w[g]] <= s_wdata_w[g];
                swe_cnt[g] = swe_cnt[g] + 1;
            end
            if (out_we_w[g]) begin
                out_mem[g][out_addr_w[g]] <= out_wdata_w[g];
                owe_cnt[g] = owe_cnt[g] + 1;
                obs_q.push_back({out_addr_w[g], out_wdata_w[g]});
            end
        end
    end

    // ---------------- scoreboard ----------------
    int          n_vec;
    int          n_err;
    logic [15:0] exp_q[$];
    logic [7:0]  exp_s  [256];
    logic [7:0]  s_init [256];
    logic [7:0]  msg_arr[256];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pack_outs(input int g);
        return {11'd0, busy_w[g], done_w[g], pass_w[g], s_we_w[g], out_we_w[g],
                s_addr_w[g], s_wdata_w[g], msg_addr_w[g], out_addr_w[g],
                out_wdata_w[g], fail_w[g]};
    endfunction

    function automatic bit is_text(input logic [7:0] c);
        return (c == 8'h20) || ((c >= 8'h61) && (c <= 8'h7A));
    endfunction

    // Software RC4 PRGA over a copy of s_init; fills exp_q with the expected
    // {addr,data} writes and exp_s with the final permutation.
    task automatic model_run(input int n, input bit chk, output bit e_pass, output int e_fail);
        logic [7:0] s[256];
        logic [7:0] t;
        logic [7:0] d;
        int i;
        int j;
        for (int x = 0; x < 256; x++) s[x] = s_init[x];
        exp_q.delete();
        i = 0;
        j = 0;
        e_pass = 1'b1;
        e_fail = 0;
        for (int k = 0; k < n; k++) begin
            i = (i + 1) % 256;
            j = (j + int'(s[i])) % 256;
            t = s[i];
            s[i] = s[j];
            s[j] = t;
            d = s[(int'(s[i]) + int'(s[j])) % 256] ^ msg_arr[k];
            if (chk && !is_text(d)) begin
                e_pass = 1'b0;
                e_fail = k;
                break;
            end
            exp_q.push_back({8'(k), d});
        end
        for (int x = 0; x < 256; x++) exp_s[x] = s[x];
    endtask

    // ---------------- driver tasks ----------------
    task automatic load_mem(input int g);
        for (int x = 0; x < 256; x++) begin
            s_mem[g][x]   = s_init[x];
            msg_mem[g][x] = msg_arr[x];
            out_mem[g][x] = 8'd0;
        end
    endtask

    task automatic set_identity();
        for (int x = 0; x < 256; x++) s_init[x] = 8'(x);
    endtask

    task automatic set_random_perm();
        logic [7:0] t;
        int r;
        set_identity();
        for (int x = 255; x > 0; x--) begin
            r = $urandom_range(x, 0);
            t = s_init[x];
            s_init[x] = s_init[r];
            s_init[r] = t;
        end
    endtask

    // One complete run on instance g, checked against the model.
    task automatic do_run(input int g, input bit chk, output int cyc);
        bit e_pass;
        int e_fail;
        int nproc;
        int nexp;
        load_mem(g);
        model_run(n_of(g), chk, e_pass, e_fail);
        obs_q.delete();
        @(negedge clk);
        check_en[g] = chk;
        start[g] = 1'b1;
        @(posedge clk);
        #1 start[g] = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!done_w[g] && cyc < 3000);
        nproc = e_pass ? n_of(g) : e_fail + 1;
        check_val("done_cycle", 64'(cyc), 64'(2 + nproc * (3 * l_of(g) + 6)));
        check_val("busy_at_done", 64'(busy_w[g]), 64'd0);
        @(negedge clk);
        check_val("done_width", 64'(done_w[g]), 64'd0);
        check_val("pass", 64'(pass_w[g]), 64'(e_pass));
        check_val("fail_k", 64'(fail_w[g]), 64'(e_fail));
        nexp = exp_q.size();
        check_val("n_writes", 64'(obs_q.size()), 64'(nexp));
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            check_val("out_write", 64'(obs_q.pop_front()), 64'(exp_q.pop_front()));
        end
        for (int x = 0; x < 256; x++) begin
            check_val("s_final", 64'(s_mem[g][x]), 64'(exp_s[x]));
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int cyc;
        int n;
        int base;
        int wsnap;
        bit found;
        bit e_pass;
        int e_fail;
        int bad;
        logic [7:0] ks[256];
        logic [7:0] plain;

        n_vec = 0;
        n_err = 0;
        for (int g = 0; g < 3; g++) begin
            start[g] = 1'b0;
            check_en[g] = 1'b0;
            swe_cnt[g] = 0;
            owe_cnt[g] = 0;
            for (int p = 0; p < 4; p++) begin
                s_pipe[g][p] = 8'd0;
                m_pipe[g][p] = 8'd0;
            end
        end
        for (int x = 0; x < 256; x++) msg_arr[x] = 8'(8'h63 + x);
        set_identity();
        for (int g = 0; g < 3; g++) load_mem(g);

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int g = 0; g < 3; g++) check_val("reset_outs", pack_outs(g), 64'd0);
        rst_n = 1'b1;

        // Identity S, check off, both latencies on a 4-byte message.
        do_run(0, 1'b0, cyc);
        check_val("id_out0", 64'(out_mem[0][0]), 64'h61);
        check_val("id_out1", 64'(out_mem[0][1]), 64'h61);
        check_val("id_s2", 64'(s_mem[0][2]), 64'd3);
        check_val("id_cyc_l1", 64'(cyc), 64'd38);
        do_run(1, 1'b0, cyc);
        check_val("id3_out0", 64'(out_mem[1][0]), 64'h61);
        check_val("id3_out1", 64'(out_mem[1][1]), 64'h61);
        check_val("id3_cyc", 64'(cyc), 64'd62);

        // Check on, byte 1 decrypts to 0x05.
        msg_arr[1] = 8'h00;
        do_run(0, 1'b1, cyc);
        check_val("chk_pass", 64'(pass_w[0]), 64'd0);
        check_val("chk_fail_k", 64'(fail_w[0]), 64'd1);
        check_val("chk_out0", 64'(out_mem[0][0]), 64'h61);
        check_val("chk_no_out1", 64'(out_mem[0][1]), 64'h00);
        msg_arr[1] = 8'h64;

        // Random permutations and messages on the 32-byte instance.
        for (int r = 0; r < 3; r++) begin
            set_random_perm();
            for (int x = 0; x < 256; x++) msg_arr[x] = 8'($urandom_range(255, 0));
            do_run(2, 1'b0, cyc);
        end

        // Crafted plaintext: all valid, then one invalid byte at a random spot.
        set_random_perm();
        for (int x = 0; x < 256; x++) msg_arr[x] = 8'd0;
        model_run(N2, 1'b0, e_pass, e_fail);
        for (int x = 0; x < N2; x++) begin
            ks[x] = exp_q[x][7:0];
            plain = ($urandom_range(3, 0) == 0) ? 8'h20 : 8'(8'h61 + $urandom_range(25, 0));
            msg_arr[x] = ks[x] ^ plain;
        end
        do_run(2, 1'b1, cyc);
        check_val("craft_pass", 64'(pass_w[2]), 64'd1);
        bad = $urandom_range(N2 - 1, 0);
        msg_arr[bad] = ks[bad] ^ 8'($urandom_range(31, 0));
        do_run(2, 1'b1, cyc);
        check_val("craft_fail_k", 64'(fail_w[2]), 64'(bad));

        // Reset asserted during WR_J of byte 2, then a clean rerun.
        set_identity();
        for (int x = 0; x < 256; x++) msg_arr[x] = 8'(8'h63 + x);
        load_mem(0);
        obs_q.delete();
        base = swe_cnt[0];
        @(negedge clk);
        check_en[0] = 1'b0;
        start[0] = 1'b1;
        @(posedge clk);
        #1 start[0] = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 300 && !found; c++) begin
            @(negedge clk);
            if (s_we_w[0] && swe_cnt[0] == base + 4) found = 1'b1;
        end
        check_val("rst_reached_wr_j", 64'(found), 64'd1);
        rst_n = 1'b0;
        #1;
        check_val("rst_mid_outs", pack_outs(0), 64'd0);
        wsnap = swe_cnt[0] + owe_cnt[0];
        repeat (3) @(negedge clk);
        check_val("rst_no_writes", 64'(swe_cnt[0] + owe_cnt[0]), 64'(wsnap));
        check_val("rst_partial_out", 64'(obs_q.size()), 64'd2);
        rst_n = 1'b1;
        do_run(0, 1'b0, cyc);

        // start held high: back-to-back runs, one per IDLE acceptance.
        load_mem(0);
        @(negedge clk);
        start[0] = 1'b1;
        @(posedge clk);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!done_w[0] && cyc < 3000);
        check_val("held_cyc", 64'(cyc), 64'd38);
        @(negedge clk);
        check_val("held_idle", {62'd0, busy_w[0], done_w[0]}, 64'd0);
        @(negedge clk);
        check_val("held_rerun_busy", 64'(busy_w[0]), 64'd1);
        n = 2;
        do begin
            @(negedge clk);
            n++;
        end while (!done_w[0] && n < 3000);
        check_val("held_gap", 64'(n), 64'd39);
        start[0] = 1'b0;
        repeat (3) @(negedge clk);

        // start pulsed while busy: no effect on timing, no extra run.
        load_mem(0);
        @(negedge clk);
        start[0] = 1'b1;
        @(posedge clk);
        #1 start[0] = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            start[0] = (cyc == 10 || cyc == 20);
        end while (!done_w[0] && cyc < 3000);
        start[0] = 1'b0;
        check_val("pulse_cyc", 64'(cyc), 64'd38);
        n = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy_w[0]) n++;
        end
        check_val("pulse_no_rerun", 64'(n), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
